// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the fetch stage.
//
// Adds a start/halt state machine, branch/jump redirect, trap entry and trap
// return with a saved exception PC, and detection of misaligned redirect
// targets on top of a plain PC register.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   startProcess  in   IDLE/HALT -> RUN request
//   haltReq       in   RUN -> HALT request
//   pcWrite       in   1 = advance, 0 = stall (from hazard unit)
//   branchTaken   in   redirect valid
//   branchTarget  in   redirect address [XLEN]
//   trapReq       in   exception/interrupt entry
//   trapRet       in   return from trap (reload saved PC)
//   pcOut         out  current fetch address [XLEN]
//   pcPlus4       out  pcOut + 4, combinational, wraps modulo 2^XLEN
//   epcOut        out  saved exception PC [XLEN]
//   misalignErr   out  one-cycle pulse after a misaligned redirect
//   running       out  1 while the FSM is in RUN (registered)
//   dbgState      out  raw FSM state (0 IDLE, 1 RUN, 2 HALT)
//   traceIdx      in   trace read index      (PC_TRACE_EN build only)
//   traceData     out  {fromPc, toPc} entry  (PC_TRACE_EN build only)
//
// Optional build macro PC_TRACE_EN adds a HIST_DEPTH-entry circular buffer
// recording every non-sequential PC change (trap, trap return, branch,
// misaligned-branch trap).
//
// Handshake note: there is no valid/ready pair here. Requests are level
// qualifiers sampled at each rising edge; in RUN exactly one PC update
// (the highest-priority one) is applied per edge and becomes visible on
// pcOut one clock later. A branch presented while pcWrite=0 is dropped, so
// the hazard unit must hold or re-assert it.

module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     TRAP_VECTOR  = 32'h0000_0100,
  parameter int              HIST_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          startProcess,
  input  logic                          haltReq,
  input  logic                          pcWrite,
  input  logic                          branchTaken,
  input  logic [XLEN-1:0]               branchTarget,
  input  logic                          trapReq,
  input  logic                          trapRet,
  output logic [XLEN-1:0]               pcOut,
  output logic [XLEN-1:0]               pcPlus4,
  output logic [XLEN-1:0]               epcOut,
  output logic                          misalignErr,
  output logic                          running,
  output logic [1:0]                    dbgState
`ifdef PC_TRACE_EN
  ,
  input  logic [$clog2(HIST_DEPTH)-1:0] traceIdx,
  output logic [2*XLEN-1:0]             traceData
`endif
);

  // Trap vector is given as 32 bits and truncated (or zero-extended) to XLEN.
  localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VECTOR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_epc;
  logic              r_misalign;
  logic              r_running;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   w_epc_nxt;
  logic [XLEN-1:0]   w_pc_plus4;
  logic              w_misalign_nxt;
  logic              w_redirect;
  logic              w_tgt_aligned;

  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_tgt_aligned = (branchTarget[1:0] == 2'b00);

  // Next-state and next-PC selection. In RUN the if/else chain encodes the
  // strict priority trap > trap return > branch > sequential > hold. A halt
  // request only changes the state; whatever update won this cycle still
  // lands.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_epc_nxt      = r_epc;
    w_misalign_nxt = 1'b0;
    w_redirect     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // PC parked at the reset vector; the start edge itself does not
        // advance, so the first fetch is at RESET_VECTOR.
        w_pc_nxt = RESET_VECTOR;
        if (startProcess) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (trapReq) begin
          w_pc_nxt   = TRAP_PC;
          w_epc_nxt  = r_pc;
          w_redirect = 1'b1;
        end else if (trapRet) begin
          w_pc_nxt   = r_epc;
          w_redirect = 1'b1;
        end else if (branchTaken && pcWrite) begin
          w_redirect = 1'b1;
          if (w_tgt_aligned) begin
            w_pc_nxt = branchTarget;
          end else begin
            // Misaligned target is handled as a trap on the branch's PC.
            w_pc_nxt       = TRAP_PC;
            w_epc_nxt      = r_pc;
            w_misalign_nxt = 1'b1;
          end
        end else if (pcWrite) begin
          w_pc_nxt = w_pc_plus4;
        end
        if (haltReq) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (startProcess) w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_VECTOR;
      r_epc      <= '0;
      r_misalign <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_epc      <= w_epc_nxt;
      r_misalign <= w_misalign_nxt;
      // Registered alongside the state so it equals (state == RUN) exactly.
      r_running  <= (w_state_nxt == ST_RUN);
    end
  end

  assign pcOut       = r_pc;
  assign pcPlus4     = w_pc_plus4;
  assign epcOut      = r_epc;
  assign misalignErr = r_misalign;
  assign running     = r_running;
  assign dbgState    = r_state;

`ifdef PC_TRACE_EN
  localparam int TRACE_AW = $clog2(HIST_DEPTH);

  logic [2*XLEN-1:0] r_trace [HIST_DEPTH];
  logic [TRACE_AW-1:0] r_wr_ptr;

  // Pointer wraps naturally because HIST_DEPTH is a power of two; once full,
  // the oldest entry is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_trace[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_redirect) begin
      r_trace[r_wr_ptr] <= {r_pc, w_pc_nxt};
      r_wr_ptr          <= r_wr_ptr + TRACE_AW'(1);
    end
  end

  assign traceData = r_trace[traceIdx];
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        startProcess, haltReq, pcWrite, branchTaken, trapReq, trapRet;
  logic [31:0] branchTarget;
  logic [31:0] pcOut, pcPlus4, epcOut;
  logic        misalignErr, running;
  logic [1:0]  dbgState;
`ifdef PC_TRACE_EN
  logic [1:0]  traceIdx;
  logic [63:0] traceData;
`endif

  logic        rst8;
  logic        start8, halt8, pw8, br8, trq8, trt8;
  logic [7:0]  tgt8;
  logic [7:0]  pc8, pc8_p4, epc8;
  logic        mis8, run8;
  logic [1:0]  state8;
`ifdef PC_TRACE_EN
  logic [1:0]  tidx8;
  logic [15:0] tdata8;
`endif

  pc_unit #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .startProcess(startProcess), .haltReq(haltReq),
    .pcWrite(pcWrite), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .trapReq(trapReq), .trapRet(trapRet), .pcOut(pcOut), .pcPlus4(pcPlus4),
    .epcOut(epcOut), .misalignErr(misalignErr), .running(running),
    .dbgState(dbgState)
`ifdef PC_TRACE_EN
    , .traceIdx(traceIdx), .traceData(traceData)
`endif
  );

  pc_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst8), .startProcess(start8), .haltReq(halt8),
    .pcWrite(pw8), .branchTaken(br8), .branchTarget(tgt8),
    .trapReq(trq8), .trapRet(trt8), .pcOut(pc8), .pcPlus4(pc8_p4),
    .epcOut(epc8), .misalignErr(mis8), .running(run8),
    .dbgState(state8)
`ifdef PC_TRACE_EN
    , .traceIdx(tidx8), .traceData(tdata8)
`endif
  );

  // ---------------- scoreboard ----------------
  // 32-bit entry: {running, misalignErr, epcOut, pcOut}
  logic [65:0] exp_q[$];
  // 8-bit entry:  {running, misalignErr, epcOut, pcOut}
  logic [17:0] exp8_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk) begin : mon32
    logic [65:0] e;
    logic [31:0] p4;
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      p4 = e[31:0] + 32'd4;
      check("pc",       64'(pcOut),       64'(e[31:0]));
      check("pc_plus4", 64'(pcPlus4),     64'(p4));
      check("epc",      64'(epcOut),      64'(e[63:32]));
      check("misalign", 64'(misalignErr), 64'(e[64]));
      check("running",  64'(running),     64'(e[65]));
    end
  end

  always @(posedge clk) begin : mon8
    logic [17:0] e;
    logic [7:0]  p4;
    #1;
    if (exp8_q.size() != 0) begin
      e  = exp8_q.pop_front();
      p4 = e[7:0] + 8'd4;
      check("pc8",       64'(pc8),    64'(e[7:0]));
      check("pc8_plus4", 64'(pc8_p4), 64'(p4));
      check("epc8",      64'(epc8),   64'(e[15:8]));
      check("misalign8", 64'(mis8),   64'(e[16]));
      check("running8",  64'(run8),   64'(e[17]));
    end
  end

  // ---------------- drivers ----------------
  task automatic drv(input logic st, input logic hr, input logic pw, input logic br,
                     input logic [31:0] tgt, input logic trq, input logic trt,
                     input logic [31:0] e_pc, input logic [31:0] e_epc,
                     input logic e_mis, input logic e_run);
    @(negedge clk);
    startProcess = st; haltReq = hr; pcWrite = pw; branchTaken = br;
    branchTarget = tgt; trapReq = trq; trapRet = trt;
    exp_q.push_back({e_run, e_mis, e_epc, e_pc});
  endtask

  task automatic drv8(input logic st, input logic hr, input logic pw, input logic br,
                      input logic [7:0] tgt, input logic [7:0] e_pc, input logic e_run);
    @(negedge clk);
    start8 = st; halt8 = hr; pw8 = pw; br8 = br; tgt8 = tgt; trq8 = 1'b0; trt8 = 1'b0;
    exp8_q.push_back({e_run, 1'b0, 8'h00, e_pc});
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && (exp_q.size() != 0 || exp8_q.size() != 0); i++) @(posedge clk);
    #2;
    check("drain", 64'(exp_q.size() + exp8_q.size()), 64'd0);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    startProcess = 0; haltReq = 0; pcWrite = 0; branchTaken = 0;
    branchTarget = '0; trapReq = 0; trapRet = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; rst8 = 1'b1;
    startProcess = 0; haltReq = 0; pcWrite = 0; branchTaken = 0;
    branchTarget = '0; trapReq = 0; trapRet = 0;
    start8 = 0; halt8 = 0; pw8 = 0; br8 = 0; tgt8 = '0; trq8 = 0; trt8 = 0;
`ifdef PC_TRACE_EN
    traceIdx = '0; tidx8 = '0;
`endif
    #12;
    check("rst_pc",    64'(pcOut),       64'd0);
    check("rst_epc",   64'(epcOut),      64'd0);
    check("rst_mis",   64'(misalignErr), 64'd0);
    check("rst_run",   64'(running),     64'd0);
    check("rst_state", 64'(dbgState),    64'd0);
    @(negedge clk); rst = 1'b0;

    // IDLE ignores everything but start
    drv(0,0,1,1,32'h40,1,1, 32'h0,  32'h0, 0, 0);
    // start, then sequential fetch 0,0,4,8,C,10
    drv(1,0,0,0,32'h0,0,0,  32'h0,  32'h0, 0, 1);
    drv(0,0,1,0,32'h0,0,0,  32'h4,  32'h0, 0, 1);
    drv(0,0,1,0,32'h0,0,0,  32'h8,  32'h0, 0, 1);
    drv(0,0,1,0,32'h0,0,0,  32'hC,  32'h0, 0, 1);
    drv(0,0,1,0,32'h0,0,0,  32'h10, 32'h0, 0, 1);
    // branch during stall is dropped
    drv(0,0,0,1,32'h40,0,0, 32'h10, 32'h0, 0, 1);
    drv(0,0,0,1,32'h40,0,0, 32'h10, 32'h0, 0, 1);
    drv(0,0,1,0,32'h0,0,0,  32'h14, 32'h0, 0, 1);
    // aligned branch, then misaligned branch -> trap with one-cycle pulse
    drv(0,0,1,1,32'h20,0,0, 32'h20, 32'h0,  0, 1);
    drv(0,0,1,1,32'h42,0,0, 32'h100,32'h20, 1, 1);
    drv(0,0,0,0,32'h0,0,0,  32'h100,32'h20, 0, 1);
    drv(0,0,0,0,32'h0,0,1,  32'h20, 32'h20, 0, 1);
    // trap beats branch, ignores pcWrite=0
    drv(0,0,1,1,32'h30,0,0, 32'h30, 32'h20, 0, 1);
    drv(0,0,0,1,32'h80,1,0, 32'h100,32'h30, 0, 1);
    drv(0,0,0,0,32'h0,0,1,  32'h30, 32'h30, 0, 1);
    // halt with a pending sequential update, then HALT ignores requests
    drv(0,1,1,0,32'h0,0,0,  32'h34, 32'h30, 0, 0);
    drv(0,0,1,1,32'h200,1,1,32'h34, 32'h30, 0, 0);
    drv(1,0,0,0,32'h0,0,0,  32'h34, 32'h30, 0, 1);
    drv(0,0,1,0,32'h0,0,0,  32'h38, 32'h30, 0, 1);
    drv(1,0,1,0,32'h0,0,0,  32'h3C, 32'h30, 0, 1);
    // trap together with halt: trap still applied
    drv(0,1,0,0,32'h0,1,0,  32'h100,32'h3C, 0, 0);
    drain();
    check("halt_state", 64'(dbgState), 64'd2);

    // asynchronous reset mid-HALT, away from any clock edge
    #2; rst = 1'b1; #1;
    check("arst_pc",    64'(pcOut),    64'd0);
    check("arst_epc",   64'(epcOut),   64'd0);
    check("arst_run",   64'(running),  64'd0);
    check("arst_state", 64'(dbgState), 64'd0);
`ifdef PC_TRACE_EN
    traceIdx = 2'd2; #1;
    check("arst_trace", traceData, 64'd0);
`endif
    idle_inputs();
    rst = 1'b0;

`ifdef PC_TRACE_EN
    // five redirects into a four-entry buffer
    drv(1,0,0,0,32'h0,0,0,   32'h0,   32'h0, 0, 1);
    drv(0,0,1,1,32'h40,0,0,  32'h40,  32'h0, 0, 1);
    drv(0,0,1,1,32'h80,0,0,  32'h80,  32'h0, 0, 1);
    drv(0,0,1,1,32'hC0,0,0,  32'hC0,  32'h0, 0, 1);
    drv(0,0,1,1,32'h100,0,0, 32'h100, 32'h0, 0, 1);
    drv(0,0,1,1,32'h140,0,0, 32'h140, 32'h0, 0, 1);
    idle_inputs();
    drain();
    traceIdx = 2'd0; #1; check("trace0", traceData, {32'h100, 32'h140});
    traceIdx = 2'd1; #1; check("trace1", traceData, {32'h40,  32'h80});
    traceIdx = 2'd3; #1; check("trace3", traceData, {32'hC0,  32'h100});
`endif

    // 8-bit instance: wrap, halt hold, async reset in HALT
    @(negedge clk); rst8 = 1'b0;
    drv8(1,0,0,0,8'h00, 8'h00, 1);
    drv8(0,0,1,1,8'hFC, 8'hFC, 1);
    drv8(0,0,1,0,8'h00, 8'h00, 1);
    drv8(0,0,1,0,8'h00, 8'h04, 1);
    drv8(0,0,1,0,8'h00, 8'h08, 1);
    drv8(0,1,1,0,8'h00, 8'h0C, 0);
    drv8(0,0,1,1,8'h20, 8'h0C, 0);
    drv8(0,0,1,0,8'h00, 8'h0C, 0);
    drain();
    check("halt8_state", 64'(state8), 64'd2);
    #2; rst8 = 1'b1; #1;
    check("arst8_pc",    64'(pc8),    64'd0);
    check("arst8_state", 64'(state8), 64'd0);
    check("arst8_run",   64'(run8),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
